// File: rtl/spi_frame_ctrl_pkg.sv
// Shared constants for the SPI frame controller: opcodes, FSM encoding and fill byte.
package spi_frame_ctrl_pkg;

  typedef logic [1:0] opcode_t;
  typedef logic [3:0] state_t;

  localparam opcode_t OP_NOP    = 2'b00;
  localparam opcode_t OP_WRITE  = 2'b01;
  localparam opcode_t OP_READ   = 2'b10;
  localparam opcode_t OP_STATUS = 2'b11;

  localparam state_t ST_SYNC    = 4'd0;
  localparam state_t ST_CMD     = 4'd1;
  localparam state_t ST_ADDR_HI = 4'd2;
  localparam state_t ST_ADDR_LO = 4'd3;
  localparam state_t ST_WR_DATA = 4'd4;
  localparam state_t ST_RD_TURN = 4'd5;
  localparam state_t ST_RD_DATA = 4'd6;
  localparam state_t ST_STAT    = 4'd7;
  localparam state_t ST_DISCARD = 4'd8;

  localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/spi_frame_ctrl.sv
// SPI command framer: decodes WRITE/READ/STATUS/NOP transactions and drives a byte-wide buffer.
module spi_frame_ctrl
  import spi_frame_ctrl_pkg::*;
#(
  parameter int         ADDR_W  = 10,
  parameter logic [7:0] ID_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_selected,
  input  logic              spi_done,
  input  logic [7:0]        spi_dout,
  output logic [7:0]        spi_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              frame_done
);

  state_t     state;
  state_t     state_next;
  opcode_t    op;
  logic [7:0] addr_hi;
  logic [7:0] prefetch;
  logic [7:0] wr_count;
  logic       is_read;
  logic       wr_seen;
  logic       stat_sent;
  logic       rd_pend;
  logic       issue_wr;
  logic       issue_rd;
  logic       ending_frame;

  assign op = spi_dout[7:6];

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    if (spi_done) begin
      case (state)
        ST_CMD: begin
          case (op)
            OP_WRITE, OP_READ: state_next = ST_ADDR_HI;
            OP_STATUS:         state_next = ST_STAT;
            default:           state_next = ST_DISCARD;
          endcase
        end
        ST_ADDR_HI: state_next = ST_ADDR_LO;
        ST_ADDR_LO: state_next = is_read ? ST_RD_TURN : ST_WR_DATA;
        ST_RD_TURN: state_next = ST_RD_DATA;
        default:    state_next = state;
      endcase
    end
    // A byte landing with deselect is still acted on above; only the state is overridden.
    if (!spi_selected) state_next = ST_CMD;
  end

  always_comb begin
    issue_wr     = spi_done && (state == ST_WR_DATA);
    issue_rd     = spi_done && (((state == ST_ADDR_LO) && is_read) ||
                                (state == ST_RD_TURN) || (state == ST_RD_DATA));
    ending_frame = !spi_selected && (state == ST_WR_DATA) && (wr_seen || spi_done);
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SYNC;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      frame_done <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'h00;
      spi_din    <= ID_BYTE;
      wr_count   <= 8'h00;
      addr_hi    <= 8'h00;
      prefetch   <= FILL_BYTE;
      is_read    <= 1'b0;
      wr_seen    <= 1'b0;
      stat_sent  <= 1'b0;
      rd_pend    <= 1'b0;
    end else begin
      state      <= state_next;
      mem_we     <= issue_wr;
      mem_re     <= issue_rd;
      rd_pend    <= mem_re;
      frame_done <= ending_frame;

      if (ending_frame) wr_count <= wr_count + 8'd1;

      // Post-increment once the strobe has used the current address.
      if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
      if (rd_pend) begin
        prefetch <= mem_rdata;
        mem_addr <= mem_addr + ADDR_W'(1);
      end

      if (issue_wr) begin
        mem_wdata <= spi_dout;
        wr_seen   <= 1'b1;
      end

      if (spi_done) begin
        case (state)
          ST_CMD: begin
            is_read   <= (op == OP_READ);
            wr_seen   <= 1'b0;
            stat_sent <= 1'b0;
            spi_din   <= FILL_BYTE;
          end
          ST_ADDR_HI: begin
            addr_hi <= spi_dout;
            spi_din <= FILL_BYTE;
          end
          ST_ADDR_LO: begin
            mem_addr <= ADDR_W'({addr_hi, spi_dout});
            spi_din  <= FILL_BYTE;
          end
          // Read data lags one byte in the prefetch register, which yields the turnaround byte.
          ST_RD_TURN, ST_RD_DATA: spi_din <= prefetch;
          ST_STAT: begin
            spi_din   <= stat_sent ? FILL_BYTE : wr_count;
            stat_sent <= 1'b1;
          end
          default: ;
        endcase
      end

      if (!spi_selected) spi_din <= ID_BYTE;
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: drives byte transactions and checks MISO bytes and memory strobes.
module tb_spi_frame_ctrl;

  localparam int         ADDR_W = 10;
  localparam logic [7:0] ID     = 8'hA5;

  logic              clk = 1'b0;
  logic              rst;
  logic              spi_selected;
  logic              spi_done;
  logic [7:0]        spi_dout;
  logic [7:0]        spi_din;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [7:0]        mem_rdata;
  logic              frame_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_frame_ctrl #(.ADDR_W(ADDR_W), .ID_BYTE(ID)) dut (
    .clk(clk), .rst(rst), .spi_selected(spi_selected), .spi_done(spi_done),
    .spi_dout(spi_dout), .spi_din(spi_din), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .frame_done(frame_done)
  );

  // Buffer model: registered read, data valid the cycle after mem_re.
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int                we_cnt = 0, re_cnt = 0, fd_cnt = 0, both_cnt = 0;
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [ADDR_W-1:0] re_addr_q[$];
  logic [7:0]        wr_data_q[$];

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (mem_re) begin
      re_cnt++;
      re_addr_q.push_back(mem_addr);
    end
    if (frame_done) fd_cnt++;
    if (mem_we && mem_re) both_cnt++;
  end

  logic [7:0] tx[$];
  logic [7:0] rx[$];
  logic [7:0] exp_q[$];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // MISO for a byte is whatever spi_din holds just before that byte completes.
  task automatic send_byte(input logic [7:0] b, output logic [7:0] miso);
    tick(4);
    miso     = spi_din;
    spi_dout = b;
    spi_done = 1'b1;
    tick(1);
    spi_done = 1'b0;
    spi_dout = 8'h00;
  endtask

  task automatic do_select();
    tick(2);
    spi_selected = 1'b1;
  endtask

  task automatic do_deselect();
    tick(3);
    spi_selected = 1'b0;
    tick(4);
  endtask

  task automatic run_xfer();
    logic [7:0] m;
    rx.delete();
    do_select();
    foreach (tx[i]) begin
      send_byte(tx[i], m);
      rx.push_back(m);
    end
    do_deselect();
  endtask

  task automatic do_reset();
    spi_selected = 1'b0;
    spi_done     = 1'b0;
    spi_dout     = 8'h00;
    rst          = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    spi_selected = 1'b0;
    spi_done     = 1'b0;
    spi_dout     = 8'h00;
    rst          = 1'b1;
    tick(3);
    tests++;
    if ({mem_we, mem_re, frame_done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_strobes got=%b want=000", {mem_we, mem_re, frame_done});
    end
    tests++;
    if (mem_addr !== '0) begin
      fails++;
      $display("FAIL reset_addr got=%h want=000", mem_addr);
    end
    tests++;
    if (mem_wdata !== 8'h00) begin
      fails++;
      $display("FAIL reset_wdata got=%h want=00", mem_wdata);
    end
    tests++;
    if (spi_din !== ID) begin
      fails++;
      $display("FAIL reset_spi_din got=%h want=%h", spi_din, ID);
    end
    rst = 1'b0;
    tick(2);
    // wr_count starts at zero
    tx    = '{8'hC0, 8'h00, 8'h00};
    exp_q = '{ID, 8'hFF, 8'h00};
    run_xfer();
    foreach (exp_q[i]) begin
      tests++;
      if (rx[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL reset_status_miso[%0d] got=%h want=%h", i, rx[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_write();
    int we0 = we_cnt, fd0 = fd_cnt, re0 = re_cnt, w0 = wr_addr_q.size();
    logic [ADDR_W-1:0] ea[3] = '{10'h110, 10'h111, 10'h112};
    logic [7:0]        ed[3] = '{8'h11, 8'h22, 8'h33};
    tx    = '{8'h40, 8'h01, 8'h10, 8'h11, 8'h22, 8'h33};
    exp_q = '{ID, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_xfer();
    tests++;
    if (we_cnt - we0 !== 3) begin
      fails++;
      $display("FAIL write_we_count got=%0d want=3", we_cnt - we0);
    end
    for (int i = 0; i < 3 && w0 + i < wr_addr_q.size(); i++) begin
      tests++;
      if (wr_addr_q[w0+i] !== ea[i] || wr_data_q[w0+i] !== ed[i]) begin
        fails++;
        $display("FAIL write_beat[%0d] got=%h/%h want=%h/%h", i,
                 wr_addr_q[w0+i], wr_data_q[w0+i], ea[i], ed[i]);
      end
    end
    tests++;
    if (fd_cnt - fd0 !== 1) begin
      fails++;
      $display("FAIL write_frame_done got=%0d want=1", fd_cnt - fd0);
    end
    tests++;
    if (re_cnt - re0 !== 0) begin
      fails++;
      $display("FAIL write_no_read got=%0d want=0", re_cnt - re0);
    end
    foreach (exp_q[i]) begin
      tests++;
      if (rx[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL write_miso[%0d] got=%h want=%h", i, rx[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_read_wrap();
    int w0 = wr_addr_q.size(), r0 = re_addr_q.size(), re0 = re_cnt, we0 = we_cnt;
    // Preload 0x3FF=AB and, by write-address wrap, 0x000=CD.
    tx = '{8'h40, 8'h03, 8'hFF, 8'hAB, 8'hCD};
    run_xfer();
    tests++;
    if (wr_addr_q.size() - w0 !== 2 || wr_addr_q[w0] !== 10'h3FF || wr_addr_q[w0+1] !== 10'h000) begin
      fails++;
      $display("FAIL write_wrap got=%0d writes want 2 at 3ff,000", wr_addr_q.size() - w0);
    end
    re0 = re_cnt;
    we0 = we_cnt;
    tx    = '{8'h80, 8'h03, 8'hFF, 8'h00, 8'h00, 8'h00};
    exp_q = '{ID, 8'hFF, 8'hFF, 8'hFF, 8'hAB, 8'hCD};
    run_xfer();
    foreach (exp_q[i]) begin
      tests++;
      if (rx[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL read_miso[%0d] got=%h want=%h", i, rx[i], exp_q[i]);
      end
    end
    tests++;
    if (re_cnt - re0 !== 4 || re_addr_q[r0] !== 10'h3FF || re_addr_q[r0+1] !== 10'h000) begin
      fails++;
      $display("FAIL read_strobes got=%0d want=4 starting 3ff,000", re_cnt - re0);
    end
    tests++;
    if (we_cnt - we0 !== 0) begin
      fails++;
      $display("FAIL read_no_write got=%0d want=0", we_cnt - we0);
    end
  endtask

  task automatic test_status();
    do_reset();
    tx = '{8'h40, 8'h00, 8'h05, 8'h77};
    run_xfer();
    tx = '{8'h7F, 8'h02, 8'h00, 8'h88, 8'h99};
    run_xfer();
    tx    = '{8'hC0, 8'h00, 8'h00, 8'h00};
    exp_q = '{ID, 8'hFF, 8'h02, 8'hFF};
    run_xfer();
    foreach (exp_q[i]) begin
      tests++;
      if (rx[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL status_miso[%0d] got=%h want=%h", i, rx[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_empty_write();
    int we0 = we_cnt, fd0 = fd_cnt;
    tx = '{8'h40, 8'h01, 8'h20};
    run_xfer();
    tests++;
    if (we_cnt - we0 !== 0 || fd_cnt - fd0 !== 0) begin
      fails++;
      $display("FAIL empty_write got we=%0d fd=%0d want 0/0", we_cnt - we0, fd_cnt - fd0);
    end
    tx    = '{8'hC0, 8'h00, 8'h00};
    exp_q = '{ID, 8'hFF, 8'h02};
    run_xfer();
    tests++;
    if (rx[2] !== 8'h02) begin
      fails++;
      $display("FAIL empty_write_count got=%h want=02", rx[2]);
    end
  endtask

  task automatic test_reset_mid();
    int we0 = we_cnt, fd0 = fd_cnt, w0;
    logic [7:0] m;
    do_select();
    send_byte(8'h40, m);
    send_byte(8'h01, m);
    send_byte(8'h30, m);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    send_byte(8'h55, m);
    send_byte(8'h66, m);
    do_deselect();
    tests++;
    if (we_cnt - we0 !== 0 || fd_cnt - fd0 !== 0) begin
      fails++;
      $display("FAIL reset_mid_discard got we=%0d fd=%0d want 0/0", we_cnt - we0, fd_cnt - fd0);
    end
    we0 = we_cnt;
    fd0 = fd_cnt;
    w0  = wr_addr_q.size();
    tx  = '{8'h40, 8'h00, 8'h40, 8'h99};
    run_xfer();
    tests++;
    if (we_cnt - we0 !== 1 || wr_addr_q[w0] !== 10'h040 || wr_data_q[w0] !== 8'h99 || fd_cnt - fd0 !== 1) begin
      fails++;
      $display("FAIL reset_mid_recover got we=%0d fd=%0d want 1 write 040/99, fd 1",
               we_cnt - we0, fd_cnt - fd0);
    end
  endtask

  task automatic test_nop();
    int we0 = we_cnt, re0 = re_cnt, fd0 = fd_cnt;
    tx    = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_q = '{ID, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_xfer();
    foreach (exp_q[i]) begin
      tests++;
      if (rx[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL nop_miso[%0d] got=%h want=%h", i, rx[i], exp_q[i]);
      end
    end
    tests++;
    if (we_cnt - we0 !== 0 || re_cnt - re0 !== 0 || fd_cnt - fd0 !== 0) begin
      fails++;
      $display("FAIL nop_strobes got we=%0d re=%0d fd=%0d want 0/0/0",
               we_cnt - we0, re_cnt - re0, fd_cnt - fd0);
    end
  endtask

  // Last data byte completes in the same cycle the slave is deselected.
  task automatic test_back_to_back();
    int we0 = we_cnt, fd0 = fd_cnt, w0 = wr_addr_q.size();
    logic [7:0] m;
    do_select();
    send_byte(8'h40, m);
    send_byte(8'h00, m);
    send_byte(8'h50, m);
    tick(4);
    spi_dout     = 8'hAA;
    spi_done     = 1'b1;
    spi_selected = 1'b0;
    tick(1);
    spi_done = 1'b0;
    tick(4);
    tests++;
    if (we_cnt - we0 !== 1 || wr_addr_q[w0] !== 10'h050 || wr_data_q[w0] !== 8'hAA) begin
      fails++;
      $display("FAIL deselect_byte_write got we=%0d want 1 write 050/aa", we_cnt - we0);
    end
    tests++;
    if (fd_cnt - fd0 !== 1) begin
      fails++;
      $display("FAIL deselect_byte_frame_done got=%0d want=1", fd_cnt - fd0);
    end
    tests++;
    if (both_cnt !== 0) begin
      fails++;
      $display("FAIL we_re_overlap got=%0d want=0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wrap();
    test_status();
    test_empty_write();
    test_reset_mid();
    test_nop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_frame_ctrl.md
SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, pixel-buffer address width.
REQ-002 SHALL have parameter ID_BYTE, default 8'hA5, value preloaded on MISO for each transaction's first byte.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port spi_selected  input  1  high while the SPI slave is selected (SS low).
REQ-006 SHALL have port spi_done  input  1  one-cycle pulse per received byte.
REQ-007 SHALL have port spi_dout  input  8  received byte, valid when spi_done=1.
REQ-008 SHALL have port spi_din  output  8  next byte to transmit; the SPI slave samples it one byte ahead.
REQ-009 SHALL have port mem_addr  output  ADDR_W  buffer address.
REQ-010 SHALL have port mem_wdata  output  8  write data.
REQ-011 SHALL have port mem_we  output  1  one-cycle write strobe.
REQ-012 SHALL have port mem_re  output  1  one-cycle read strobe.
REQ-013 SHALL have port mem_rdata  input  8  read data, valid exactly 1 cycle after mem_re.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse when a WRITE transaction with at least one data byte ends.

Function
REQ-015 SHALL frame transactions by spi_selected; byte 0 is the command, where cmd[7:6] 01=WRITE, 10=READ, 11=STATUS, 00=NOP; cmd[5:0] are ignored.
REQ-016 SHALL, for WRITE/READ, take byte 1 as addr[ADDR_W-1:8] (upper bits ignored) and byte 2 as addr[7:0].
REQ-017 SHALL use states SYNC, CMD, ADDR_HI, ADDR_LO, WR_DATA, RD_TURN, RD_DATA, STAT, DISCARD.
REQ-018 SHALL transition CMD->ADDR_HI on WRITE/READ, CMD->STAT on STATUS, CMD->DISCARD on NOP, ADDR_HI->ADDR_LO, ADDR_LO->WR_DATA (WRITE) or RD_TURN (READ), RD_TURN->RD_DATA, each on spi_done.
REQ-019 SHALL, in WR_DATA on each spi_done, assert mem_we for exactly the next cycle with mem_addr=current address and mem_wdata=spi_dout, then increment the address.
REQ-020 SHALL, on spi_done in ADDR_LO (READ), RD_TURN and RD_DATA, pulse mem_re on the next cycle at the current address, capture mem_rdata into spi_din one cycle later, then increment the address.
REQ-021 SHALL give a READ the MISO byte sequence ID_BYTE, FF, FF, FF (turnaround), mem[a], mem[a+1], and so on.
REQ-022 SHALL give a STATUS command the MISO sequence ID_BYTE, FF, wr_count, then FF for all further bytes.
REQ-023 SHALL make wr_count an 8-bit count of frame_done pulses, wrapping 255->0.
REQ-024 SHALL, when not otherwise loaded, hold spi_din at 8'hFF in active states and at ID_BYTE in CMD.
REQ-025 SHALL change spi_din within 3 cycles of spi_done and hold it stable until the next spi_done.
REQ-026 SHALL wrap the address from 2^ADDR_W-1 to 0.
REQ-027 SHALL, when spi_selected falls in any state, go to CMD the next cycle; frame_done pulses and wr_count increments in that cycle only if the ending state was WR_DATA with at least one write.
REQ-028 SHALL process a byte that arrives with spi_done in the same cycle spi_selected falls (write or read issued) before ending the transaction.
REQ-029 SHALL never assert mem_we and mem_re in the same cycle.
REQ-030 SHALL ignore all spi_done pulses in DISCARD and in SYNC.

Reset
REQ-031 SHALL, on rst, enter SYNC with mem_we=0, mem_re=0, frame_done=0, mem_addr=0, mem_wdata=0, spi_din=ID_BYTE and wr_count=0.
REQ-032 SHALL leave SYNC for CMD only after sampling spi_selected=0, so a reset during a transaction discards that transaction's remaining bytes.

Structure
REQ-033 SHALL place opcode constants (OP_NOP, OP_WRITE, OP_READ, OP_STATUS), the state encoding and the FF fill value in a shared package.
REQ-034 SHALL be a single module with no sub-module; the read-prefetch register sits inline.

Verification
REQ-035 SHALL cover: WRITE 0x40,0x01,0x10,0x11,0x22,0x33 -> mem_we three times at 0x110/0x111/0x112 with 0x11/0x22/0x33; frame_done once on deselect.
REQ-036 SHALL cover: mem preloaded 0x3FF=0xAB, 0x000=0xCD; READ 0x80,0x03,0xFF,x,x,x -> MISO A5,FF,FF,FF,AB,CD (address wrap).
REQ-037 SHALL cover: two WRITE transactions, then STATUS 0xC0,x,x -> MISO A5,FF,02.
REQ-038 SHALL cover: WRITE with only cmd+address bytes, then deselect -> no mem_we, no frame_done.
REQ-039 SHALL cover: rst asserted after addr_lo of a WRITE while still selected -> later data bytes produce no mem_we; the next transaction after deselect works normally.
REQ-040 SHALL cover: NOP 0x00 followed by 4 bytes -> no memory strobes and MISO FF after ID_BYTE.
